// File: rtl/instruction_fetch_buffer_if.sv
// Fetch-buffer bus: redirect, instruction-cache request/response and decode handshake.
// The master modport is the fetch buffer; the slave modport is its environment.
interface instruction_fetch_buffer_if;
  logic        redirect_i;
  logic [31:0] redirect_address_i;
  logic        fetch_o;
  logic [31:0] program_counter_o;
  logic [31:0] icache_instruction_i;
  logic        icache_valid_i;
  logic [31:0] instruction_o;
  logic [31:0] pc_o;
  logic        valid_o;
  logic        ready_i;

  modport master (
    input  redirect_i, redirect_address_i, icache_instruction_i, icache_valid_i, ready_i,
    output fetch_o, program_counter_o, instruction_o, pc_o, valid_o
  );

  modport slave (
    output redirect_i, redirect_address_i, icache_instruction_i, icache_valid_i, ready_i,
    input  fetch_o, program_counter_o, instruction_o, pc_o, valid_o
  );
endinterface

// File: rtl/instruction_fetch_buffer.sv
// Sequential fetch PC generator with a small {pc, instruction} queue feeding decode.
// Redirects flush the queue and drop any response still owed by the cache.
module instruction_fetch_buffer #(
  parameter int unsigned BUFFER_DEPTH = 4,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input logic                         clk_i,
  input logic                         rst_n_i,
  instruction_fetch_buffer_if.master  bus
);
  localparam int unsigned PtrW = $clog2(BUFFER_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StFetch, StWait, StDiscard} state_e;

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [PtrW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [31:0]       pc_mem_q [BUFFER_DEPTH];
  logic [31:0]       pc_mem_d [BUFFER_DEPTH];
  logic [31:0]       instr_mem_q [BUFFER_DEPTH];
  logic [31:0]       instr_mem_d [BUFFER_DEPTH];
  logic              fetch, push, pop;

  always_comb begin
    // Gated by reset so no request leaks out while the block is held in reset.
    fetch = rst_n_i && (state_q == StFetch) && (count_q < CntW'(BUFFER_DEPTH)) &&
            !bus.redirect_i;
    push  = !bus.redirect_i && bus.icache_valid_i &&
            (((state_q == StFetch) && fetch) || (state_q == StWait));
    pop   = !bus.redirect_i && (count_q != '0) && bus.ready_i;

    state_d     = state_q;
    pc_d        = pc_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;

    if (bus.redirect_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      pc_d    = {bus.redirect_address_i[31:2], 2'b00};
      unique case (state_q)
        StWait, StDiscard: state_d = bus.icache_valid_i ? StFetch : StDiscard;
        default:           state_d = StFetch;
      endcase
    end else begin
      if (push) begin
        pc_mem_d[tail_q]    = pc_q;
        instr_mem_d[tail_q] = bus.icache_instruction_i;
        tail_d              = tail_q + 1'b1;
        pc_d                = pc_q + 32'd4;
      end
      if (pop) begin
        head_d = head_q + 1'b1;
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
      unique case (state_q)
        StFetch:   if (fetch && !bus.icache_valid_i) state_d = StWait;
        StWait:    if (bus.icache_valid_i) state_d = StFetch;
        StDiscard: if (bus.icache_valid_i) state_d = StFetch;
        default:   state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= StFetch;
      pc_q        <= RESET_VECTOR;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      pc_mem_q    <= '{default: '0};
      instr_mem_q <= '{default: '0};
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      pc_mem_q    <= pc_mem_d;
      instr_mem_q <= instr_mem_d;
    end
  end

  assign bus.fetch_o           = fetch;
  assign bus.program_counter_o = pc_q;
  assign bus.instruction_o     = instr_mem_q[head_q];
  assign bus.pc_o              = pc_mem_q[head_q];
  assign bus.valid_o           = (count_q != '0);
endmodule

// File: tb/tb_instruction_fetch_buffer.sv
// Randomised bench for instruction_fetch_buffer against a queue-based reference model.
module tb_instruction_fetch_buffer;
  localparam int unsigned Depth    = 4;
  localparam logic [31:0] ResetVec = 32'h0000_0000;

  typedef struct packed {logic [31:0] pc; logic [31:0] ins;} entry_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  instruction_fetch_buffer_if bus ();

  instruction_fetch_buffer #(
    .BUFFER_DEPTH(Depth),
    .RESET_VECTOR(ResetVec)
  ) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Reference model: queue contents, next fetch PC, request-owed flag, drop-next flag.
  entry_t      mq[$];
  logic [31:0] m_pc;
  bit          m_out, m_disc;
  // Cache model: response owed after c_cnt more cycles.
  bit          c_busy;
  int          c_cnt;

  logic        exp_fetch, obs_fetch, exp_valid;
  entry_t      exp_head;

  task automatic model_reset();
    mq.delete();
    m_pc = ResetVec;
    m_out = 0;
    m_disc = 0;
    c_busy = 0;
    c_cnt = 0;
    exp_valid = 0;
    exp_head = '0;
  endtask

  // Drives one cycle, advances the model, returns #1 after the rising edge.
  task automatic step(input bit redir, input logic [31:0] raddr, input bit rdy, input int lat);
    bit cv;
    logic [31:0] cdata;
    bus.redirect_i = redir;
    bus.redirect_address_i = raddr;
    bus.ready_i = rdy;
    exp_fetch = !m_out && (mq.size() < Depth) && !redir;
    cv = 0;
    cdata = $urandom;
    if (c_busy) begin
      c_cnt--;
      if (c_cnt == 0) begin
        cv = 1;
        c_busy = 0;
      end
    end else if (exp_fetch) begin
      if (lat == 0) cv = 1;
      else begin
        c_busy = 1;
        c_cnt = lat;
      end
    end
    bus.icache_valid_i = cv;
    bus.icache_instruction_i = cv ? cdata : 32'hDEAD_BEEF;
    #1 obs_fetch = bus.fetch_o;
    if (redir) begin
      mq.delete();
      m_pc = {raddr[31:2], 2'b00};
      if (m_out && !cv) m_disc = 1;
      else begin
        m_out = 0;
        m_disc = 0;
      end
    end else begin
      if (mq.size() != 0 && rdy) void'(mq.pop_front());
      if (cv) begin
        if (!m_disc) begin
          mq.push_back({m_pc, cdata});
          m_pc = m_pc + 32'd4;
        end
        m_out = 0;
        m_disc = 0;
      end else if (exp_fetch) begin
        m_out = 1;
      end
    end
    exp_valid = (mq.size() != 0);
    exp_head = exp_valid ? mq[0] : '0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.redirect_i = 0;
    bus.redirect_address_i = '0;
    bus.ready_i = 0;
    bus.icache_valid_i = 0;
    bus.icache_instruction_i = '0;
    model_reset();
    #1;
    if ({bus.fetch_o, bus.valid_o, bus.instruction_o, bus.pc_o} !== 66'd0) begin
      mismatched++;
      $display("FAIL reset outputs fetch=%0b valid=%0b ins=%h pc=%h exp all zero",
               bus.fetch_o, bus.valid_o, bus.instruction_o, bus.pc_o);
    end
    compared++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    if (bus.program_counter_o !== ResetVec) begin
      mismatched++;
      $display("FAIL reset program_counter got %h exp %h", bus.program_counter_o, ResetVec);
    end
    compared++;
  endtask

  task automatic test_hit_stream();
    for (int i = 0; i < 10; i++) begin
      step(0, '0, 1, 0);
      if (obs_fetch !== exp_fetch || obs_fetch !== 1'b1) begin
        mismatched++;
        $display("FAIL hits fetch_o got %0b exp 1", obs_fetch);
      end
      compared++;
      if (bus.valid_o !== exp_valid || bus.program_counter_o !== m_pc ||
          (exp_valid && {bus.pc_o, bus.instruction_o} !== exp_head)) begin
        mismatched++;
        $display("FAIL hits outputs got v=%0b pc=%h ins=%h fpc=%h exp v=%0b head=%h fpc=%h",
                 bus.valid_o, bus.pc_o, bus.instruction_o, bus.program_counter_o,
                 exp_valid, exp_head, m_pc);
      end
      compared++;
    end
    if (bus.program_counter_o !== 32'h28 || bus.pc_o !== 32'h24) begin
      mismatched++;
      $display("FAIL hits_pcs got fpc=%h pc=%h exp fpc=00000028 pc=00000024",
               bus.program_counter_o, bus.pc_o);
    end
    compared++;
  endtask

  task automatic test_full_queue();
    step(1, 32'h0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      // Six cycles stalled, one pop, one refill.
      step(0, '0, (i == 6), 0);
      if (obs_fetch !== exp_fetch) begin
        mismatched++;
        $display("FAIL full fetch_o cycle %0d got %0b exp %0b", i, obs_fetch, exp_fetch);
      end
      compared++;
      if (bus.valid_o !== exp_valid || bus.program_counter_o !== m_pc ||
          (exp_valid && {bus.pc_o, bus.instruction_o} !== exp_head)) begin
        mismatched++;
        $display("FAIL full outputs got v=%0b pc=%h ins=%h fpc=%h exp v=%0b head=%h fpc=%h",
                 bus.valid_o, bus.pc_o, bus.instruction_o, bus.program_counter_o,
                 exp_valid, exp_head, m_pc);
      end
      compared++;
      if (i == 5 && (obs_fetch !== 1'b0 || bus.program_counter_o !== 32'h10)) begin
        mismatched++;
        $display("FAIL full_stall got fetch=%0b fpc=%h exp fetch=0 fpc=00000010",
                 obs_fetch, bus.program_counter_o);
      end
      if (i == 7 && (obs_fetch !== 1'b1 || bus.program_counter_o !== 32'h14)) begin
        mismatched++;
        $display("FAIL full_refill got fetch=%0b fpc=%h exp fetch=1 fpc=00000014",
                 obs_fetch, bus.program_counter_o);
      end
      if (i == 5 || i == 7) compared++;
    end
  endtask

  task automatic test_miss();
    step(1, 32'h20, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, '0, 0, 3);
      if (obs_fetch !== exp_fetch) begin
        mismatched++;
        $display("FAIL miss fetch_o cycle %0d got %0b exp %0b", i, obs_fetch, exp_fetch);
      end
      compared++;
      if (i == 3 && (bus.valid_o !== 1'b1 || bus.pc_o !== 32'h20 ||
                     bus.instruction_o !== exp_head.ins || bus.program_counter_o !== 32'h24)) begin
        mismatched++;
        $display("FAIL miss_entry got v=%0b pc=%h ins=%h fpc=%h exp v=1 pc=20 ins=%h fpc=24",
                 bus.valid_o, bus.pc_o, bus.instruction_o, bus.program_counter_o, exp_head.ins);
      end
      if (i == 3) compared++;
    end
  endtask

  task automatic test_redirect_wait();
    step(1, 32'h40, 1, 0);
    step(0, '0, 1, 3);
    step(1, 32'h103, 1, 0);
    if (bus.program_counter_o !== 32'h100 || bus.valid_o !== 1'b0) begin
      mismatched++;
      $display("FAIL redir_wait target got fpc=%h v=%0b exp fpc=00000100 v=0",
               bus.program_counter_o, bus.valid_o);
    end
    compared++;
    for (int i = 0; i < 5; i++) begin
      step(0, '0, 0, 0);
      if (obs_fetch !== exp_fetch) begin
        mismatched++;
        $display("FAIL redir_wait fetch_o cycle %0d got %0b exp %0b", i, obs_fetch, exp_fetch);
      end
      compared++;
    end
    if (bus.valid_o !== 1'b1 || bus.pc_o !== 32'h100 || bus.instruction_o !== exp_head.ins) begin
      mismatched++;
      $display("FAIL redir_wait head got v=%0b pc=%h ins=%h exp v=1 pc=00000100 ins=%h",
               bus.valid_o, bus.pc_o, bus.instruction_o, exp_head.ins);
    end
    compared++;
  endtask

  task automatic test_redirect_full();
    step(1, 32'h200, 0, 0);
    repeat (5) step(0, '0, 0, 0);
    step(1, 32'h300, 1, 0);
    if (bus.valid_o !== 1'b0 || bus.program_counter_o !== 32'h300 || exp_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL redir_full got v=%0b fpc=%h exp v=0 fpc=00000300",
               bus.valid_o, bus.program_counter_o);
    end
    compared++;
  endtask

  task automatic test_wrap();
    step(1, 32'hFFFF_FFF8, 0, 0);
    repeat (3) step(0, '0, 0, 0);
    if (bus.pc_o !== 32'hFFFF_FFF8 || bus.program_counter_o !== 32'h0000_0004 ||
        mq.size() != 3 || mq[2].pc !== 32'h0) begin
      mismatched++;
      $display("FAIL wrap got pc=%h fpc=%h exp pc=fffffff8 fpc=00000004",
               bus.pc_o, bus.program_counter_o);
    end
    compared++;
    step(0, '0, 1, 0);
    if (bus.pc_o !== 32'hFFFF_FFFC) begin
      mismatched++;
      $display("FAIL wrap_pop got pc=%h exp fffffffc", bus.pc_o);
    end
    compared++;
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      step(($urandom_range(0, 19) == 0), $urandom, 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 3)));
      if (obs_fetch !== exp_fetch) begin
        mismatched++;
        $display("FAIL random fetch_o cycle %0d got %0b exp %0b", i, obs_fetch, exp_fetch);
      end
      compared++;
      if (bus.valid_o !== exp_valid || bus.program_counter_o !== m_pc ||
          (exp_valid && {bus.pc_o, bus.instruction_o} !== exp_head)) begin
        mismatched++;
        $display("FAIL random outputs cycle %0d got v=%0b pc=%h ins=%h fpc=%h exp v=%0b head=%h fpc=%h",
                 i, bus.valid_o, bus.pc_o, bus.instruction_o, bus.program_counter_o,
                 exp_valid, exp_head, m_pc);
      end
      compared++;
    end
  endtask

  task automatic test_async_reset();
    step(1, 32'h400, 0, 0);
    step(0, '0, 0, 0);
    step(0, '0, 0, 2);
    #3 rst_n = 0;
    #1;
    if (bus.valid_o !== 1'b0 || bus.fetch_o !== 1'b0 || bus.program_counter_o !== ResetVec) begin
      mismatched++;
      $display("FAIL async_reset got v=%0b fetch=%0b fpc=%h exp v=0 fetch=0 fpc=%h",
               bus.valid_o, bus.fetch_o, bus.program_counter_o, ResetVec);
    end
    compared++;
    bus.redirect_i = 0;
    bus.icache_valid_i = 0;
    bus.ready_i = 0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1;
  endtask

  initial begin
    test_reset();
    test_hit_stream();
    test_full_queue();
    test_miss();
    test_redirect_wait();
    test_redirect_full();
    test_wrap();
    test_random(300);
    test_async_reset();
    test_random(300);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_buffer.md
# instruction_fetch_buffer

Fetch-side sequencer and instruction queue sitting directly downstream of the instruction cache complex and upstream of the decode stage. It generates the sequential fetch program counter and issues single-cycle fetch requests to the cache. It captures returned instructions together with their PC into a small FIFO, and presents them to decode through a valid/ready handshake. A redirect (taken branch, jump, trap) flushes the queue, retargets the PC and discards any in-flight cache response.

## Interface
Parameters:
- `BUFFER_DEPTH`, default 4: number of queue entries; power of two, ≥ 2.
- `RESET_VECTOR`, default 32'h0000_0000: fetch PC after reset; bits [1:0] must be 0.

Ports:
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_n_i`  in  1  reset, asynchronous, active-low.
- `redirect_i`  in  1  single-cycle request to restart fetch at `redirect_address_i`.
- `redirect_address_i`  in  32  new fetch PC; bits [1:0] are ignored and forced to 0.
- `fetch_o`  out  1  one-cycle fetch request to the cache.
- `program_counter_o`  out  32  fetch PC; stable while a request is outstanding.
- `icache_instruction_i`  in  32  instruction returned by the cache.
- `icache_valid_i`  in  1  `icache_instruction_i` is valid. It may arrive in the same cycle as `fetch_o` (hit) or in any later cycle (miss).
- `instruction_o`  out  32  instruction at the head of the queue.
- `pc_o`  out  32  PC of the head instruction.
- `valid_o`  out  1  the queue is non-empty.
- `ready_i`  in  1  decode accepts the head entry when `valid_o & ready_i`.

## Operation
- Storage: `BUFFER_DEPTH` entries of {pc[31:0], instruction[31:0]}, with head/tail pointers of width log2(`BUFFER_DEPTH`) and a count of width log2(`BUFFER_DEPTH`)+1. Pointers wrap modulo `BUFFER_DEPTH`.
- State machine:
  - FETCH: may issue a request.
  - WAIT: a request is outstanding.
  - DISCARD: an outstanding request is to be dropped.
- `fetch_o` = (state == FETCH) & (count < `BUFFER_DEPTH`) & !`redirect_i`. Combinational; at most one request is outstanding at any time.
- Response handling:
  - FETCH with `fetch_o` and `icache_valid_i`: push {PC, instruction}, then PC ← PC + 4. State stays FETCH.
  - FETCH with `fetch_o` and no `icache_valid_i`: go to WAIT, holding PC.
  - WAIT with `icache_valid_i`: push, PC ← PC + 4, go to FETCH.
  - DISCARD with `icache_valid_i`: drop the data, go to FETCH; PC is not incremented.
- Push never overflows: a request is only issued with a free slot, and no push occurs without a request.
- Pop on `valid_o & ready_i`: head advances and count decrements. Push and pop in the same cycle leave count unchanged.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Redirect (`redirect_i` = 1), which has priority over push and pop in the same cycle:
  - count, head and tail reset to 0;
  - PC ← {`redirect_address_i`[31:2], 2'b00};
  - any `icache_valid_i` in that cycle is dropped.
  - Next state by current state:
    - FETCH → FETCH (no request is issued in the redirect cycle);
    - WAIT with `icache_valid_i` → FETCH;
    - WAIT without `icache_valid_i` → DISCARD;
    - DISCARD with `icache_valid_i` → FETCH;
    - DISCARD without `icache_valid_i` → DISCARD.
- Reset values:
  - state FETCH;
  - PC = `RESET_VECTOR`, so `program_counter_o` = `RESET_VECTOR`;
  - count and pointers 0; all entries cleared;
  - `valid_o` 0, `instruction_o` 0, `pc_o` 0;
  - `fetch_o` 0 while `rst_n_i` is low.
- Reset asserted mid-operation discards the queue and any outstanding request immediately (asynchronous).

## Timing
- Hit path: `fetch_o` and `icache_valid_i` in cycle N → entry visible on `valid_o`/`instruction_o` in cycle N+1. The next sequential `fetch_o` is in N+1 if a slot is free.
- Sustained throughput is one instruction per cycle on hits with `ready_i` = 1.
- Miss path: response in cycle N+k → entry visible in N+k+1, next fetch in N+k+1.
- Redirect in cycle R (state FETCH) → first fetch of the new PC in R+1. `valid_o` = 0 in R+1 unless a new entry was pushed in R+1, in which case it shows in R+2.
- Full queue: `fetch_o` stays low. A pop in cycle F re-enables `fetch_o` in F+1.
- `instruction_o`, `pc_o` and `valid_o` are driven from registered state only; there is no combinational path from the cache inputs.

## Test plan
- Reset release, cache always hits, `ready_i` = 1 → `fetch_o` every cycle. PCs 0x0, 0x4, 0x8… and `pc_o` follows one cycle later; `valid_o` stays high.
- `ready_i` = 0 with hits and `BUFFER_DEPTH` = 4 → exactly 4 pushes, then `fetch_o` = 0. Raising `ready_i` for one cycle → one pop, one new fetch at PC 0x10 the next cycle.
- Miss: `icache_valid_i` 3 cycles after `fetch_o` at PC 0x20 → `fetch_o` low for 3 cycles, then entry {0x20, data} and the next fetch at 0x24.
- Redirect to 0x103 while in WAIT; stale response 2 cycles later → stale data is dropped. The next fetch is at PC 0x100, and the queue holds only new-path entries.
- Redirect in the same cycle as push and pop with a full queue → queue empty next cycle, `valid_o` = 0, and the fetch PC equals the redirect target.
- Start at PC 32'hFFFF_FFF8 via redirect, with hits → fetched PCs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000. Asserting `rst_n_i` low mid-stream immediately gives `valid_o` = 0 and `fetch_o` = 0.
